// File: rtl/line_block_scheduler_if.sv
// Writer/reader handshake bundle of the line block scheduler.
// Revision: 1.0 - initial release
`default_nettype none

interface line_block_scheduler_if #(
  parameter int BLOCK_COUNT    = 2,
  parameter int ADDRESS_NUMBER = 562,
  parameter int MAX_HEIGHT     = 1080,
  parameter int DROP_CNT_BITS  = 16
);
  localparam int PTR_W  = $clog2(BLOCK_COUNT);
  localparam int ROW_W  = $clog2(MAX_HEIGHT);
  localparam int WORD_W = $clog2(ADDRESS_NUMBER + 1);
  localparam int CNT_W  = $clog2(BLOCK_COUNT + 1);

  logic                     frame_start;
  logic                     row_start;
  logic                     row_end;
  logic                     word_valid;
  logic                     wr_enable;
  logic [PTR_W-1:0]         wr_block;
  logic                     rd_valid;
  logic [PTR_W-1:0]         rd_block;
  logic [ROW_W-1:0]         rd_row;
  logic [WORD_W-1:0]        rd_words;
  logic                     rd_done;
  logic [CNT_W-1:0]         free_count;
  logic                     row_dropped;
  logic [DROP_CNT_BITS-1:0] drop_count;
  logic                     overflow;

  modport slave (
    input  frame_start, row_start, row_end, word_valid, rd_done,
    output wr_enable, wr_block, rd_valid, rd_block, rd_row, rd_words,
           free_count, row_dropped, drop_count, overflow
  );

  modport master (
    output frame_start, row_start, row_end, word_valid, rd_done,
    input  wr_enable, wr_block, rd_valid, rd_block, rd_row, rd_words,
           free_count, row_dropped, drop_count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/line_block_scheduler.sv
// line_block_scheduler: assigns video rows to line buffer blocks and queues them to the reader.
// Revision: 1.0 - initial release
`default_nettype none

module line_block_scheduler #(
  parameter int BLOCK_COUNT    = 2,
  parameter int ADDRESS_NUMBER = 562,
  parameter int MAX_HEIGHT     = 1080,
  parameter int DROP_CNT_BITS  = 16
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  line_block_scheduler_if.slave  bus
);
  localparam int PTR_W  = $clog2(BLOCK_COUNT);
  localparam int ROW_W  = $clog2(MAX_HEIGHT);
  localparam int WORD_W = $clog2(ADDRESS_NUMBER + 1);
  localparam int CNT_W  = $clog2(BLOCK_COUNT + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BLOCK_COUNT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MAX_HEIGHT - 1);
  localparam logic [WORD_W-1:0] WORDS_MAX = WORD_W'(ADDRESS_NUMBER);
  localparam logic [CNT_W-1:0]  BLOCKS    = CNT_W'(BLOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    FILL     = 2'd2,
    SKIP     = 2'd3
  } state_t;

  state_t                   state, state_next;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_next, count_after;
  logic [ROW_W-1:0]         row, row_next, row_inc;
  logic [WORD_W-1:0]        words, words_next, words_eff;
  logic [ROW_W-1:0]         row_mem   [BLOCK_COUNT];
  logic [WORD_W-1:0]        words_mem [BLOCK_COUNT];
  logic [CNT_W-1:0]         free_count;
  logic [DROP_CNT_BITS-1:0] drop_count;
  logic                     row_dropped, overflow;
  logic                     wr_en, pop, end_event, commit, block_free, drop;

  always_comb begin
    state_next  = state;
    row_next    = row;
    words_next  = words;
    drop        = 1'b0;
    wr_en       = (state == FILL) && bus.word_valid && (words < WORDS_MAX);
    words_eff   = words + WORD_W'(wr_en);
    pop         = bus.rd_done && (count != '0);
    end_event   = ((state == FILL) || (state == SKIP)) &&
                  (bus.row_end || bus.row_start) && !bus.frame_start;
    commit      = end_event && (state == FILL) && (words_eff != '0);
    count_after = count + CNT_W'(commit);
    // A release in the same cycle frees a block for the incoming row.
    block_free  = (count_after - CNT_W'(pop)) < BLOCKS;
    row_inc     = (row == ROW_LAST) ? row : row + ROW_W'(1);
    count_next  = count_after - CNT_W'(pop);

    if (bus.frame_start) begin
      row_next   = '0;
      words_next = '0;
      state_next = WAIT_ROW;
    end else begin
      case (state)
        WAIT_ROW: begin
          if (bus.row_start) begin
            if (block_free) begin
              state_next = FILL;
              words_next = '0;
            end else begin
              state_next = SKIP;
              drop       = 1'b1;
            end
          end
        end
        FILL, SKIP: begin
          if (state == FILL) words_next = words_eff;
          if (end_event) begin
            row_next   = row_inc;
            state_next = WAIT_ROW;
            if (bus.row_start) begin
              if (block_free) begin
                state_next = FILL;
                words_next = '0;
              end else begin
                state_next = SKIP;
                drop       = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      row         <= '0;
      words       <= '0;
      free_count  <= BLOCKS;
      drop_count  <= '0;
      row_dropped <= 1'b0;
      overflow    <= 1'b0;
      for (int i = 0; i < BLOCK_COUNT; i++) begin
        row_mem[i]   <= '0;
        words_mem[i] <= '0;
      end
    end else begin
      state       <= state_next;
      row         <= row_next;
      words       <= words_next;
      count       <= count_next;
      free_count  <= BLOCKS - count_next;
      row_dropped <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      if ((state == FILL) && bus.word_valid && (words == WORDS_MAX)) overflow <= 1'b1;
      if (commit) begin
        row_mem[wr_ptr]   <= row;
        words_mem[wr_ptr] <= words_eff;
        wr_ptr            <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  assign bus.wr_enable   = wr_en;
  assign bus.wr_block    = wr_ptr;
  assign bus.rd_valid    = (count != '0);
  assign bus.rd_block    = rd_ptr;
  assign bus.rd_row      = row_mem[rd_ptr];
  assign bus.rd_words    = words_mem[rd_ptr];
  assign bus.free_count  = free_count;
  assign bus.row_dropped = row_dropped;
  assign bus.drop_count  = drop_count;
  assign bus.overflow    = overflow;
endmodule

`default_nettype wire
